// File: rtl/regfile_mp_if.sv
// ============================================================================
// regfile_mp_if : read/write/scoreboard bus of the multi-port register file
// Revision 1.0
// ============================================================================
`default_nettype none

interface regfile_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2
);
    logic                             clear_i;
    logic                             ready_o;
    logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr_i;
    logic [READ_PORTS*DATA_WIDTH-1:0] rd_data_o;
    logic [READ_PORTS-1:0]            rd_pending_o;
    logic                             wa_en_i;
    logic [ADDR_WIDTH-1:0]            wa_addr_i;
    logic [DATA_WIDTH-1:0]            wa_data_i;
    logic                             wb_en_i;
    logic [ADDR_WIDTH-1:0]            wb_addr_i;
    logic [DATA_WIDTH-1:0]            wb_data_i;
    logic                             pend_set_i;
    logic [ADDR_WIDTH-1:0]            pend_addr_i;

    modport master (
        output clear_i, rd_addr_i, wa_en_i, wa_addr_i, wa_data_i,
               wb_en_i, wb_addr_i, wb_data_i, pend_set_i, pend_addr_i,
        input  ready_o, rd_data_o, rd_pending_o
    );

    modport slave (
        input  clear_i, rd_addr_i, wa_en_i, wa_addr_i, wa_data_i,
               wb_en_i, wb_addr_i, wb_data_i, pend_set_i, pend_addr_i,
        output ready_o, rd_data_o, rd_pending_o
    );
endinterface

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp : N-read / 2-write register file with bypass, scoreboard, clear engine
// Revision 1.0
// ============================================================================
`default_nettype none

module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    regfile_mp_if.slave bus
);
    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam bit                    ZR        = (ZERO_REG != 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                         state_q;
    logic [ADDR_WIDTH-1:0]          clr_cnt_q;
    logic                           ready_q;
    logic [DEPTH-1:0]               pend_q;
    logic [DEPTH-1:0]               pend_d;
    logic [DATA_WIDTH-1:0]          mem_q [DEPTH];

    logic                           wa_we_w;
    logic                           wb_we_w;
    logic [READ_PORTS*DATA_WIDTH-1:0] rd_data_w;
    logic [READ_PORTS-1:0]          rd_pend_w;
    logic [ADDR_WIDTH-1:0]          rd_addr_w;
    logic                           hit_a_w;
    logic                           hit_b_w;

    // Port B owns a colliding address, so A is suppressed rather than ordered.
    assign wb_we_w = (state_q == ST_RUN) && !bus.clear_i && bus.wb_en_i &&
                     !(ZR && (bus.wb_addr_i == '0));
    assign wa_we_w = (state_q == ST_RUN) && !bus.clear_i && bus.wa_en_i &&
                     !(ZR && (bus.wa_addr_i == '0)) &&
                     !(bus.wb_en_i && (bus.wb_addr_i == bus.wa_addr_i));

    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else begin
            if (wa_we_w) mem_q[bus.wa_addr_i] <= bus.wa_data_i;
            if (wb_we_w) mem_q[bus.wb_addr_i] <= bus.wb_data_i;
        end
    end

    // A new producer (set) takes precedence over a retiring write on the same register.
    always_comb begin
        pend_d = pend_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (bus.pend_set_i && (bus.pend_addr_i == ADDR_WIDTH'(r)) && !(ZR && (r == 0))) begin
                pend_d[r] = 1'b1;
            end else if ((bus.wa_en_i && (bus.wa_addr_i == ADDR_WIDTH'(r))) ||
                         (bus.wb_en_i && (bus.wb_addr_i == ADDR_WIDTH'(r)))) begin
                pend_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            pend_q    <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q   <= ST_RUN;
                        ready_q   <= 1'b1;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.clear_i) begin
                        state_q   <= ST_CLEAR;
                        ready_q   <= 1'b0;
                        clr_cnt_q <= '0;
                        pend_q    <= '0;
                    end else begin
                        pend_q <= pend_d;
                    end
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    ready_q   <= 1'b0;
                    clr_cnt_q <= '0;
                    pend_q    <= '0;
                end
            endcase
        end
    end

    always_comb begin
        rd_data_w = '0;
        rd_pend_w = '0;
        rd_addr_w = '0;
        hit_a_w   = 1'b0;
        hit_b_w   = 1'b0;
        for (int i = 0; i < READ_PORTS; i++) begin
            rd_addr_w = bus.rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            hit_b_w   = bus.wb_en_i && (bus.wb_addr_i == rd_addr_w);
            hit_a_w   = bus.wa_en_i && (bus.wa_addr_i == rd_addr_w);
            if (ready_q) begin
                if (ZR && (rd_addr_w == '0)) begin
                    rd_data_w[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                end else if (hit_b_w) begin
                    rd_data_w[i*DATA_WIDTH +: DATA_WIDTH] = bus.wb_data_i;
                end else if (hit_a_w) begin
                    rd_data_w[i*DATA_WIDTH +: DATA_WIDTH] = bus.wa_data_i;
                end else begin
                    rd_data_w[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr_w];
                end
                rd_pend_w[i] = pend_q[rd_addr_w] & ~(hit_a_w | hit_b_w);
            end
        end
    end

    assign bus.ready_o      = ready_q;
    assign bus.rd_data_o    = rd_data_w;
    assign bus.rd_pending_o = rd_pend_w;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// tb_regfile_mp : table vectors, corner sequences and random traffic vs model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int RP    = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP)) bus ();

    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .ZERO_REG(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int nvec  = 0;
    int nfail = 0;

    // Reference model: architectural contents, pending set, and cycles left in a sweep.
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_pend [DEPTH];
    bit            m_ready;
    int            m_left;

    logic          s_ready;
    logic [DW-1:0] s_rd [RP];
    logic          s_pd [RP];

    typedef struct {
        logic          wa_en;
        logic [AW-1:0] wa_addr;
        logic [DW-1:0] wa_data;
        logic          wb_en;
        logic [AW-1:0] wb_addr;
        logic [DW-1:0] wb_data;
        logic          pset;
        logic [AW-1:0] paddr;
        logic [AW-1:0] r0;
        logic [AW-1:0] r1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic          ep0;
        logic          ep1;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ready = 1'b0;
        m_left  = DEPTH;
        for (int r = 0; r < DEPTH; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        if (!m_ready || a == 0) return '0;
        if (bus.wb_en_i && bus.wb_addr_i == a) return bus.wb_data_i;
        if (bus.wa_en_i && bus.wa_addr_i == a) return bus.wa_data_i;
        return m_mem[a];
    endfunction

    function automatic logic m_pd(input logic [AW-1:0] a);
        if (!m_ready) return 1'b0;
        return m_pend[a] && !((bus.wb_en_i && bus.wb_addr_i == a) ||
                              (bus.wa_en_i && bus.wa_addr_i == a));
    endfunction

    task automatic m_edge();
        if (rst) begin
            m_reset();
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) m_ready = 1'b1;
        end else if (bus.clear_i) begin
            m_reset();
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                if (bus.pend_set_i && bus.pend_addr_i == r)
                    m_pend[r] = 1'b1;
                else if ((bus.wa_en_i && bus.wa_addr_i == r) || (bus.wb_en_i && bus.wb_addr_i == r))
                    m_pend[r] = 1'b0;
            end
            if (bus.wb_en_i && bus.wb_addr_i != 0)
                m_mem[bus.wb_addr_i] = bus.wb_data_i;
            else if (bus.wa_en_i && bus.wa_addr_i != 0)
                m_mem[bus.wa_addr_i] = bus.wa_data_i;
            if (bus.wb_en_i && bus.wa_en_i && bus.wa_addr_i != bus.wb_addr_i && bus.wa_addr_i != 0)
                m_mem[bus.wa_addr_i] = bus.wa_data_i;
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cyc();
        logic [AW-1:0] a;
        @(negedge clk);
        s_ready = bus.ready_o;
        chk("ready", {31'd0, bus.ready_o}, {31'd0, m_ready});
        for (int i = 0; i < RP; i++) begin
            a       = bus.rd_addr_i[i*AW +: AW];
            s_rd[i] = bus.rd_data_o[i*DW +: DW];
            s_pd[i] = bus.rd_pending_o[i];
            chk($sformatf("rd_data%0d[r%0d]", i, a), s_rd[i], m_rd(a));
            chk($sformatf("rd_pending%0d[r%0d]", i, a), {31'd0, s_pd[i]}, {31'd0, m_pd(a)});
        end
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        bus.clear_i     = 1'b0;
        bus.wa_en_i     = 1'b0;
        bus.wa_addr_i   = '0;
        bus.wa_data_i   = '0;
        bus.wb_en_i     = 1'b0;
        bus.wb_addr_i   = '0;
        bus.wb_data_i   = '0;
        bus.pend_set_i  = 1'b0;
        bus.pend_addr_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        cyc();
        rst = 1'b0;
    endtask

    task automatic measure_sweep(input string name);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            cyc();
            if (s_ready) done = 1'b1;
            else         n++;
        end
        chk(name, n, 32);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd9, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 5'd9, 5'd7, 32'h2, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd7, 32'h2, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h2, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 32'h2, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd9, 32'h0, 32'h2, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h33, 32'h33, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h33, 32'h33, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h44, 1'b1, 5'd3, 5'd3, 5'd9, 32'h44, 32'h2, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9, 32'h44, 32'h2, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 5'd4, 32'hA5, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd3, 5'd4, 32'h44, 32'hA5, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd3, 32'hA5, 32'h44, 1'b1, 1'b1};

        idle();
        bus.rd_addr_i = '0;

        // Power-on sweep, then preload r5 and reset again.
        do_reset();
        measure_sweep("sweep_after_poweron");
        bus.wa_en_i = 1'b1; bus.wa_addr_i = 5'd5; bus.wa_data_i = 32'h1234;
        cyc();
        idle();
        bus.rd_addr_i = {5'd0, 5'd5};
        cyc();
        chk("r5_preload", s_rd[0], 32'h1234);
        do_reset();
        measure_sweep("sweep_after_reset");
        cyc();
        chk("r5_after_reset", s_rd[0], 32'h0);

        for (int v = 0; v < 14; v++) begin
            bus.wa_en_i     = tbl[v].wa_en;
            bus.wa_addr_i   = tbl[v].wa_addr;
            bus.wa_data_i   = tbl[v].wa_data;
            bus.wb_en_i     = tbl[v].wb_en;
            bus.wb_addr_i   = tbl[v].wb_addr;
            bus.wb_data_i   = tbl[v].wb_data;
            bus.pend_set_i  = tbl[v].pset;
            bus.pend_addr_i = tbl[v].paddr;
            bus.rd_addr_i   = {tbl[v].r1, tbl[v].r0};
            cyc();
            chk($sformatf("tbl%0d_d0", v), s_rd[0], tbl[v].e0);
            chk($sformatf("tbl%0d_d1", v), s_rd[1], tbl[v].e1);
            chk($sformatf("tbl%0d_p0", v), {31'd0, s_pd[0]}, {31'd0, tbl[v].ep0});
            chk($sformatf("tbl%0d_p1", v), {31'd0, s_pd[1]}, {31'd0, tbl[v].ep1});
        end

        // Mid-operation clear with r4 holding data and pending; the clear-edge write is dropped.
        idle();
        bus.clear_i = 1'b1;
        bus.wa_en_i = 1'b1; bus.wa_addr_i = 5'd6; bus.wa_data_i = 32'h66;
        bus.rd_addr_i = {5'd3, 5'd4};
        cyc();
        idle();
        measure_sweep("sweep_after_clear");
        bus.rd_addr_i = {5'd6, 5'd4};
        cyc();
        chk("r4_after_clear", s_rd[0], 32'h0);
        chk("r4_pend_after_clear", {31'd0, s_pd[0]}, 32'h0);
        chk("r6_clear_edge_write", s_rd[1], 32'h0);

        // Reset ten steps into a sweep restarts it from zero.
        bus.clear_i = 1'b1;
        cyc();
        idle();
        repeat (10) cyc();
        do_reset();
        measure_sweep("sweep_restart_mid");

        // Randomised traffic against the model.
        for (int k = 0; k < 600; k++) begin
            bus.wa_en_i     = 1'($urandom_range(0, 1));
            bus.wa_addr_i   = AW'($urandom_range(0, 7));
            bus.wa_data_i   = $urandom;
            bus.wb_en_i     = 1'($urandom_range(0, 1));
            bus.wb_addr_i   = AW'($urandom_range(0, 7));
            bus.wb_data_i   = $urandom;
            bus.pend_set_i  = 1'($urandom_range(0, 1));
            bus.pend_addr_i = AW'($urandom_range(0, 7));
            bus.rd_addr_i   = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31))};
            bus.clear_i     = ($urandom_range(0, 127) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
